ts_capture_sched: RTL and testbench

TS_CAPTURE_SCHED -- requirements
Module: ts_capture_sched

---
 rtl/ts_capture_sched_pkg.sv | 17 +
 rtl/ts_sched_fifo.sv | 65 ++++++
 rtl/ts_capture_sched.sv | 149 ++++++++++++++
 tb/tb_ts_capture_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_capture_sched_pkg.sv
// Shared definitions for the trigger capture scheduler: default sizing and
// the FSM state encoding, also used by the bench through dbg_state.
package ts_capture_sched_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TAG_W   = 8;
  localparam int DEF_ACK_TMO = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLDOFF   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/ts_sched_fifo.sv
// Pending-trigger queue: synchronous FIFO with registered full/empty/count.
// A push to a full queue is accepted when a pop happens in the same cycle.
module ts_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk_link,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count;
    if (push_ok && !pop_ok) begin
      count_d = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == FULL_CNT);
      empty <= (count_d == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_link) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ts_capture_sched.sv
// Capture scheduler: queues tagged triggers from the link and issues them one
// at a time to the capture engine, with ack timeout and post-capture holdoff.
// Handshake: cap_trigger is a one-cycle request; the engine acknowledges by
// dropping cap_done, and signals completion by raising cap_done again.
module ts_capture_sched
  import ts_capture_sched_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int ACK_TMO = DEF_ACK_TMO
) (
  input  logic                   clk_link,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   link_up,
  input  logic                   trig_in,
  input  logic [TAG_W-1:0]       trig_tag,
  input  logic                   cap_done,
  input  logic [7:0]             holdoff,
  input  logic                   clr_err,
  output logic                   cap_trigger,
  output logic [TAG_W-1:0]       cap_tag,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic [15:0]            dropped,
  output logic                   overflow_err,
  output logic                   timeout_err,
  output sched_state_t           dbg_state
);

  localparam int ACK_W = $clog2(ACK_TMO + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TMO - 1);

  sched_state_t     state_q;
  sched_state_t     state_d;
  logic             pop;
  logic             push;
  logic             drop_evt;
  logic             ovf_evt;
  logic             timeout_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] fifo_head;
  logic [ACK_W-1:0] ack_cnt;
  logic [7:0]       hold_cnt;

  // A full queue still takes the trigger if the head leaves this cycle.
  assign push     = trig_in & link_up & (~fifo_full | pop);
  assign drop_evt = trig_in & ~push;
  assign ovf_evt  = trig_in & link_up & ~push;

  ts_sched_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W)
  ) u_fifo (
    .clk_link  (clk_link),
    .reset     (reset),
    .push      (push),
    .push_data (trig_tag),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  // State register.
  always_ff @(posedge clk_link) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a zero holdoff skips HOLDOFF entirely.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty && cap_done) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        pop     = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!cap_done) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          timeout_evt = 1'b1;
          state_d     = (holdoff == 8'd0) ? ST_IDLE : ST_HOLDOFF;
        end
      end
      ST_WAIT_DONE: begin
        if (cap_done) state_d = (holdoff == 8'd0) ? ST_IDLE : ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_cnt <= 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag latched on the way into ISSUE so it is valid with cap_trigger;
  // ack timer cleared in ISSUE; holdoff sampled on HOLDOFF entry.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      cap_tag  <= '0;
      ack_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_ISSUE) cap_tag <= fifo_head;
      if (state_q == ST_ISSUE) begin
        ack_cnt <= '0;
      end else if (state_q == ST_WAIT_ACK && ack_cnt != ACK_LAST) begin
        ack_cnt <= ack_cnt + 1'b1;
      end
      if (state_d == ST_HOLDOFF && state_q != ST_HOLDOFF) begin
        hold_cnt <= holdoff;
      end else if (state_q == ST_HOLDOFF) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

  // Sticky errors and saturating drop count; a new event beats clr_err.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      dropped      <= '0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (clr_err) begin
        dropped <= drop_evt ? 16'd1 : 16'd0;
      end else if (drop_evt && dropped != 16'hFFFF) begin
        dropped <= dropped + 16'd1;
      end
      if (ovf_evt)      overflow_err <= 1'b1;
      else if (clr_err) overflow_err <= 1'b0;
      if (timeout_evt)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

  assign cap_trigger = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ts_capture_sched.sv
// Directed bench for ts_capture_sched with a tag scoreboard.
module tb_ts_capture_sched;
  import ts_capture_sched_pkg::*;

  logic         clk_link = 1'b0;
  logic         reset;
  logic         enable;
  logic         link_up;
  logic         trig_in;
  logic [7:0]   trig_tag;
  logic         cap_done;
  logic [7:0]   holdoff;
  logic         clr_err;
  logic         cap_trigger;
  logic [7:0]   cap_tag;
  logic         busy;
  logic [2:0]   pending;
  logic [15:0]  dropped;
  logic         overflow_err;
  logic         timeout_err;
  sched_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_count = 0;
  int base;
  int trig_snap;
  logic [7:0] exp_q[$];

  ts_capture_sched dut (
    .clk_link     (clk_link),
    .reset        (reset),
    .enable       (enable),
    .link_up      (link_up),
    .trig_in      (trig_in),
    .trig_tag     (trig_tag),
    .cap_done     (cap_done),
    .holdoff      (holdoff),
    .clr_err      (clr_err),
    .cap_trigger  (cap_trigger),
    .cap_tag      (cap_tag),
    .busy         (busy),
    .pending      (pending),
    .dropped      (dropped),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk_link = ~clk_link;
  always @(posedge clk_link) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_link);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Play the capture engine for one request: ack, stay busy, then finish.
  task automatic serve_one(input int hold);
    int n = 0;
    while (cap_trigger !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    assert (cap_trigger === 1'b1) else begin
      errors++;
      $error("FAIL serve_wait observed=%b expected=1", cap_trigger);
    end
    tick();
    cap_done = 1'b0;
    repeat (hold) tick();
    cap_done = 1'b1;
  endtask

  // Scoreboard: every issued capture must carry the oldest expected tag.
  always @(negedge clk_link) begin
    logic [7:0] exp_tag;
    if (cap_trigger === 1'b1) begin
      trig_count++;
      exp_tag = 8'hxx;
      if (exp_q.size() != 0) exp_tag = exp_q.pop_front();
      checks++;
      assert (cap_tag === exp_tag) else begin
        errors++;
        $error("FAIL issued_tag observed=%0h expected=%0h", cap_tag, exp_tag);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; link_up = 1'b1; trig_in = 1'b0;
    trig_tag = 8'h00; cap_done = 1'b1; holdoff = 8'd0; clr_err = 1'b0;
    tick(); tick();
    @(negedge clk_link);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_trig", 32'(cap_trigger), 0);
    chk("rst_tag", 32'(cap_tag), 0);
    chk("rst_dropped", 32'(dropped), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    reset = 1'b0;

    // Single trigger with full capture cycle and holdoff of 3
    enable = 1'b1; holdoff = 8'd3;
    tick();
    base = cyc; trig_in = 1'b1; trig_tag = 8'h5A; exp_q.push_back(8'h5A);
    tick();
    trig_in = 1'b0;
    @(negedge clk_link); chk("single_pending", 32'(pending), 1);
    go_to(base + 2);
    @(negedge clk_link); chk("single_latency", 32'(cap_trigger), 1);
    go_to(base + 3);
    @(negedge clk_link); chk("single_wait_ack", 32'(dbg_state), 32'(ST_WAIT_ACK));
    go_to(base + 4); cap_done = 1'b0;
    go_to(base + 5);
    @(negedge clk_link); chk("single_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    go_to(base + 30); cap_done = 1'b1;
    go_to(base + 31);
    @(negedge clk_link); chk("single_holdoff", 32'(dbg_state), 32'(ST_HOLDOFF));
    go_to(base + 33);
    @(negedge clk_link); chk("single_busy_hi", 32'(busy), 1);
    go_to(base + 34);
    @(negedge clk_link); chk("single_busy_lo", 32'(busy), 0);
    chk("single_tag_hold", 32'(cap_tag), 32'h5A);

    // Burst of 6 while capture is not idle: 4 queued, 2 dropped
    holdoff = 8'd0; cap_done = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      trig_tag = 8'h11 + 8'(i);
      trig_in = 1'b1;
      if (i < 4) exp_q.push_back(trig_tag);
      tick();
    end
    trig_in = 1'b0;
    @(negedge clk_link);
    chk("burst_pending", 32'(pending), 4);
    chk("burst_dropped", 32'(dropped), 2);
    chk("burst_ovf", 32'(overflow_err), 1);
    cap_done = 1'b1;
    for (int i = 0; i < 4; i++) serve_one(3);
    repeat (4) tick();
    @(negedge clk_link);
    chk("burst_drain", 32'(pending), 0);
    chk("burst_idle", 32'(busy), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk_link);
    chk("clr_ovf", 32'(overflow_err), 0);
    chk("clr_dropped", 32'(dropped), 0);

    // No acknowledge: timeout, then holdoff of 2
    holdoff = 8'd2; cap_done = 1'b1;
    tick();
    base = cyc; trig_in = 1'b1; trig_tag = 8'h77; exp_q.push_back(8'h77);
    tick();
    trig_in = 1'b0;
    go_to(base + 18);
    @(negedge clk_link);
    chk("tmo_early", 32'(timeout_err), 0);
    chk("tmo_early_state", 32'(dbg_state), 32'(ST_WAIT_ACK));
    go_to(base + 19);
    @(negedge clk_link);
    chk("tmo_set", 32'(timeout_err), 1);
    chk("tmo_holdoff", 32'(dbg_state), 32'(ST_HOLDOFF));
    go_to(base + 20);
    @(negedge clk_link); chk("tmo_busy_hi", 32'(busy), 1);
    go_to(base + 21);
    @(negedge clk_link); chk("tmo_idle", 32'(dbg_state), 32'(ST_IDLE));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk_link); chk("tmo_clr", 32'(timeout_err), 0);

    // Full queue with push and pop in the same cycle
    holdoff = 8'd0; cap_done = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      trig_tag = 8'h21 + 8'(i);
      trig_in = 1'b1;
      exp_q.push_back(trig_tag);
      tick();
    end
    trig_in = 1'b0; cap_done = 1'b1;
    @(negedge clk_link); chk("full_pending", 32'(pending), 4);
    tick();
    trig_in = 1'b1; trig_tag = 8'h25; exp_q.push_back(8'h25);
    @(negedge clk_link); chk("full_issue", 32'(cap_trigger), 1);
    tick();
    trig_in = 1'b0; cap_done = 1'b0;
    @(negedge clk_link);
    chk("pushpop_pending", 32'(pending), 4);
    chk("pushpop_dropped", 32'(dropped), 0);
    chk("pushpop_ovf", 32'(overflow_err), 0);
    repeat (2) tick();
    cap_done = 1'b1;
    for (int i = 0; i < 4; i++) serve_one(2);
    repeat (4) tick();
    @(negedge clk_link); chk("pushpop_drain", 32'(pending), 0);

    // Link down drops without overflow; clr_err loses to a new drop
    link_up = 1'b0; trig_in = 1'b1; trig_tag = 8'h99;
    tick();
    trig_in = 1'b0;
    @(negedge clk_link);
    chk("link_dropped", 32'(dropped), 1);
    chk("link_ovf", 32'(overflow_err), 0);
    chk("link_pending", 32'(pending), 0);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    @(negedge clk_link); chk("link_dropped2", 32'(dropped), 2);
    trig_in = 1'b1; clr_err = 1'b1;
    tick();
    trig_in = 1'b0; clr_err = 1'b0; link_up = 1'b1;
    @(negedge clk_link); chk("clr_vs_drop", 32'(dropped), 1);

    // Reset during WAIT_DONE discards in-flight and queued triggers
    holdoff = 8'd0; cap_done = 1'b1;
    tick();
    base = cyc; trig_in = 1'b1; trig_tag = 8'h33; exp_q.push_back(8'h33);
    tick();
    trig_tag = 8'h44;
    tick();
    trig_in = 1'b0;
    go_to(base + 3); cap_done = 1'b0;
    go_to(base + 4);
    @(negedge clk_link);
    chk("mid_state", 32'(dbg_state), 32'(ST_WAIT_DONE));
    chk("mid_pending", 32'(pending), 1);
    trig_snap = trig_count;
    reset = 1'b1;
    tick();
    reset = 1'b0; cap_done = 1'b1;
    @(negedge clk_link);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_tag", 32'(cap_tag), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_dropped", 32'(dropped), 0);
    repeat (10) tick();
    @(negedge clk_link);
    chk("mid_no_trigger", 32'(trig_count), 32'(trig_snap));
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
